// File: rtl/sms_msg_assembler.sv
// Packs a valid/ready byte stream into a parallel MS-byte-first message word with length, label and truncation flag.
// msg_valid rises 1 cycle after the last beat; in_ready is low only while a message is held; it returns the cycle after the msg handshake.
module sms_msg_assembler #(
  parameter int MAX_LENGTH = 160,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  input  logic                    in_label,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [MAX_LENGTH*8-1:0] msg,
  output logic [LEN_W-1:0]        msg_length,
  output logic                    msg_label,
  output logic                    msg_truncated,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic [CNT_W-1:0]        msg_count
);

  localparam int BW = $clog2(MAX_LENGTH*8);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LENGTH);

  typedef enum logic [1:0] {COLLECT, DISCARD, HOLD} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [MAX_LENGTH*8-1:0]   r_msg;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_idx;
  logic                      r_label;
  logic                      r_trunc;
  logic [CNT_W-1:0]          r_count;
  logic                      w_accept;
  logic                      w_deliver;
  logic [BW-1:0]             w_base;

  assign w_accept  = in_valid && (r_state != HOLD);
  assign w_deliver = (r_state == HOLD) && msg_ready;
  // Slot 0 lands in the most significant byte; only meaningful while r_idx < MAX_LENGTH.
  assign w_base    = BW'((MAX_LENGTH - 1 - int'(r_idx)) * 8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (in_last)                              w_next = HOLD;
          else if (r_idx == MAX_LEN - LEN_W'(1))    w_next = DISCARD;
        end
      end
      DISCARD: if (w_accept && in_last) w_next = HOLD;
      HOLD:    if (msg_ready)           w_next = COLLECT;
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_label <= 1'b0;
      r_trunc <= 1'b0;
      r_count <= '0;
    end else if (w_deliver) begin
      r_msg   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_trunc <= 1'b0;
      r_count <= r_count + CNT_W'(1);
    end else if (w_accept) begin
      if (r_state == COLLECT) begin
        r_msg[w_base +: 8] <= in_data;
        r_idx              <= r_idx + LEN_W'(1);
        if (in_last) begin
          r_len   <= r_idx + LEN_W'(1);
          r_label <= in_label;
        end
      end else begin
        r_trunc <= 1'b1;
        if (in_last) begin
          r_len   <= MAX_LEN;
          r_label <= in_label;
        end
      end
    end
  end

  assign in_ready      = (r_state != HOLD);
  assign msg_valid     = (r_state == HOLD);
  assign msg           = r_msg;
  assign msg_length    = r_len;
  assign msg_label     = r_label;
  assign msg_truncated = r_trunc;
  assign msg_count     = r_count;

endmodule

// File: tb/tb_sms_msg_assembler.sv
// Directed and randomized checks of sms_msg_assembler against a queue-based message model.
module tb_sms_msg_assembler;

  localparam int ML = 160;
  localparam int W  = ML * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_label;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  msg;
  logic [7:0]    msg_length;
  logic          msg_label;
  logic          msg_truncated;
  logic          msg_valid;
  logic          msg_ready;
  logic [15:0]   msg_count;

  logic [7:0]    cur[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            exp_count = 0;

  sms_msg_assembler dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_label(in_label), .in_valid(in_valid), .in_ready(in_ready),
    .msg(msg), .msg_length(msg_length), .msg_label(msg_label),
    .msg_truncated(msg_truncated), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int bi;
    logic [7:0] ob, eb;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      bi = -1; ob = 8'h00; eb = 8'h00;
      for (int i = 0; i < ML; i++) begin
        if (bi < 0 && (8'(obs >> (W - 8 - 8*i)) !== 8'(exp >> (W - 8 - 8*i)))) begin
          bi = i;
          ob = 8'(obs >> (W - 8 - 8*i));
          eb = 8'(exp >> (W - 8 - 8*i));
        end
      end
      $error("FAIL %s: first differing byte slot %0d observed 0x%0h expected 0x%0h", tag, bi, ob, eb);
    end
  endtask

  // Drives the bytes in cur as one message; bub is the percentage of idle cycles.
  task automatic send(input logic lbl, input int bub);
    int i;
    int guard;
    bit v;
    bit acc;
    i = 0;
    guard = 0;
    while (i < cur.size() && guard < 4000) begin
      v        = ($urandom_range(0, 99) >= bub);
      in_valid = v;
      in_data  = v ? cur[i] : 8'($urandom);
      in_last  = (i == cur.size() - 1);
      in_label = lbl;
      acc      = v && in_ready;
      if (v) chk("in_ready_collect", 64'(in_ready), 64'd1);
      tick;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < cur.size()) chk("send_timeout", 64'(i), 64'(cur.size()));
  endtask

  // Expects the message modelled from cur to be presented now, holds it, then hands it off.
  task automatic check_msg(input logic lbl, input int hold);
    logic [W-1:0] e;
    int n;
    int len;
    n   = cur.size();
    len = (n > ML) ? ML : n;
    e   = '0;
    for (int i = 0; i < len; i++) e = e | ({cur[i], {(W-8){1'b0}}} >> (8*i));
    chk("msg_valid_latency", 64'(msg_valid), 64'd1);
    chk_wide("msg", msg, e);
    chk("msg_length", 64'(msg_length), 64'(len));
    chk("msg_label", 64'(msg_label), 64'(lbl));
    chk("msg_truncated", 64'(msg_truncated), 64'(n > ML));
    if (!msg_ready) begin
      for (int h = 0; h < hold; h++) begin
        tick;
        chk("hold_valid", 64'(msg_valid), 64'd1);
        chk_wide("hold_msg", msg, e);
        chk("hold_length", 64'(msg_length), 64'(len));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
    end
    msg_ready = 1'b1;
    tick;
    msg_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    chk("valid_drop", 64'(msg_valid), 64'd0);
    chk("msg_count", 64'(msg_count), 64'(exp_count));
    chk_wide("msg_clear", msg, '0);
    chk("length_clear", 64'(msg_length), 64'd0);
    chk("trunc_clear", 64'(msg_truncated), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_label  = 1'b0;
    in_valid  = 1'b0;
    msg_ready = 1'b0;
    #2;
    chk("rst_valid", 64'(msg_valid), 64'd0);
    chk("rst_count", 64'(msg_count), 64'd0);
    chk("rst_length", 64'(msg_length), 64'd0);
    chk("rst_label", 64'(msg_label), 64'd0);
    chk("rst_trunc", 64'(msg_truncated), 64'd0);
    chk_wide("rst_msg", msg, '0);
    #20;
    reset = 1'b0;
    tick;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // "Hi" with msg_ready already high
    cur = '{8'h48, 8'h69};
    msg_ready = 1'b1;
    send(1'b1, 0);
    check_msg(1'b1, 0);

    // exactly full message
    cur.delete();
    for (int k = 0; k < ML; k++) cur.push_back(8'(8'h41 + k));
    send(1'b0, 0);
    chk("full_last_byte", 64'(msg[7:0]), 64'hE0);
    check_msg(1'b0, 2);

    // overflow by three bytes
    cur.delete();
    for (int k = 0; k < ML; k++) cur.push_back(8'(8'h41 + k));
    for (int k = 0; k < 3; k++) cur.push_back(8'hFF);
    send(1'b1, 0);
    chk("trunc_last_byte", 64'(msg[7:0]), 64'hE0);
    check_msg(1'b1, 1);

    // backpressure: "B" waits on in_valid while "A" is held
    cur = '{8'h41};
    send(1'b0, 0);
    in_valid = 1'b1;
    in_data  = 8'h42;
    in_last  = 1'b1;
    in_label = 1'b1;
    check_msg(1'b0, 5);
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cur = '{8'h42};
    check_msg(1'b1, 0);
    chk("bp_count", 64'(msg_count), 64'd5);

    // reset in the middle of a message
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + k);
      in_last  = 1'b0;
      tick;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("midrst_count", 64'(msg_count), 64'd0);
    chk_wide("midrst_msg", msg, '0);
    chk("midrst_valid", 64'(msg_valid), 64'd0);
    reset = 1'b0;
    exp_count = 0;
    tick;
    cur = '{8'h5A};
    send(1'b0, 0);
    check_msg(1'b0, 0);
    chk("midrst_final_count", 64'(msg_count), 64'd1);

    // randomized messages with bubbles
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_count = 0;
    tick;
    for (int m = 0; m < 20; m++) begin
      int n;
      logic lbl;
      n = (m == 0) ? 170 : (m == 1) ? ML : int'($urandom_range(1, 170));
      lbl = 1'($urandom);
      cur.delete();
      for (int k = 0; k < n; k++) cur.push_back(8'($urandom));
      msg_ready = 1'($urandom);
      send(lbl, 50);
      check_msg(lbl, int'($urandom_range(0, 3)));
    end
    chk("final_count", 64'(msg_count), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
